// File: rtl/press_pkg.sv
// Shared types and defaults for the button press decoder.
package press_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESSED = 2'd1,
      ST_LONG    = 2'd2
   } press_state_e;

   localparam int unsigned PRESS_LONG_CYC_DEF   = 100_000_000;
   localparam int unsigned PRESS_REPEAT_CYC_DEF = 20_000_000;

   // Bits needed to hold (max_cyc - 1); never less than one bit.
   function automatic int unsigned press_cnt_w(input int unsigned max_cyc);
      int unsigned w;
      w = $clog2(max_cyc);
      return (w < 1) ? 1 : w;
   endfunction

   localparam int unsigned PRESS_CNT_W_DEF =
      press_cnt_w((PRESS_LONG_CYC_DEF > PRESS_REPEAT_CYC_DEF) ?
                  PRESS_LONG_CYC_DEF : PRESS_REPEAT_CYC_DEF);

endpackage

// File: rtl/press_decoder.sv
// Turns a debounced button level into press/release/click/long (and optional
// auto-repeat) one-cycle pulses. Auto-repeat: define PRESS_DECODER_AUTO_REPEAT_EN.
module press_decoder
   import press_pkg::*;
#(
   parameter int unsigned LONG_CYC   = PRESS_LONG_CYC_DEF,
   parameter int unsigned REPEAT_CYC = PRESS_REPEAT_CYC_DEF,
   parameter int unsigned CNT_W      = PRESS_CNT_W_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic click_pulse,
   output logic long_pulse,
   output logic repeat_pulse,
   output logic held
);

   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);

   if (LONG_CYC < 2 || LONG_CYC > (64'd1 << CNT_W) - 1) begin : g_bad_long
      $error("press_decoder: LONG_CYC out of range for CNT_W");
   end
   if (REPEAT_CYC < 2 || REPEAT_CYC > (64'd1 << CNT_W) - 1) begin : g_bad_repeat
      $error("press_decoder: REPEAT_CYC out of range for CNT_W");
   end

   press_state_e     r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_press;
   logic             r_release;
   logic             r_click;
   logic             r_long;
   logic             r_held;

`ifdef PRESS_DECODER_AUTO_REPEAT_EN
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYC - 1);
   logic r_repeat;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
         r_click   <= 1'b0;
         r_long    <= 1'b0;
         r_held    <= 1'b0;
`ifdef PRESS_DECODER_AUTO_REPEAT_EN
         r_repeat  <= 1'b0;
`endif
      end else begin
         r_press   <= 1'b0;
         r_release <= 1'b0;
         r_click   <= 1'b0;
         r_long    <= 1'b0;
`ifdef PRESS_DECODER_AUTO_REPEAT_EN
         r_repeat  <= 1'b0;
`endif
         case (r_state)
            ST_IDLE: begin
               if (btn_level) begin
                  r_state <= ST_PRESSED;
                  r_cnt   <= '0;
                  r_press <= 1'b1;
                  r_held  <= 1'b1;
               end
            end
            ST_PRESSED: begin
               // Release takes priority over reaching the long threshold.
               if (!btn_level) begin
                  r_state   <= ST_IDLE;
                  r_cnt     <= '0;
                  r_release <= 1'b1;
                  r_click   <= 1'b1;
                  r_held    <= 1'b0;
               end else if (r_cnt == LONG_LAST) begin
                  r_state <= ST_LONG;
                  r_cnt   <= '0;
                  r_long  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_LONG: begin
               if (!btn_level) begin
                  r_state   <= ST_IDLE;
                  r_cnt     <= '0;
                  r_release <= 1'b1;
                  r_held    <= 1'b0;
               end else begin
`ifdef PRESS_DECODER_AUTO_REPEAT_EN
                  if (r_cnt == REPEAT_LAST) begin
                     r_cnt    <= '0;
                     r_repeat <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
`else
                  r_cnt <= '0;
`endif
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_cnt   <= '0;
               r_held  <= 1'b0;
            end
         endcase
      end
   end

   assign press_pulse   = r_press;
   assign release_pulse = r_release;
   assign click_pulse   = r_click;
   assign long_pulse    = r_long;
   assign held          = r_held;

`ifdef PRESS_DECODER_AUTO_REPEAT_EN
   assign repeat_pulse = r_repeat;
`else
   assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_press_decoder.sv
// Self-checking bench for press_decoder: vector table, directed corner cases,
// and random level streams against an elapsed-time reference model.
module tb_press_decoder;

   localparam int unsigned LONG_CYC   = 8;
   localparam int unsigned REPEAT_CYC = 3;
   localparam int unsigned CNT_W      = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic btn_level = 1'b0;
   logic press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse, held;

   press_decoder #(
      .LONG_CYC   (LONG_CYC),
      .REPEAT_CYC (REPEAT_CYC),
      .CNT_W      (CNT_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .btn_level     (btn_level),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .click_pulse   (click_pulse),
      .long_pulse    (long_pulse),
      .repeat_pulse  (repeat_pulse),
      .held          (held)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Model: a hold is described only by the edge index at which it started.
   int cyc    = 0;
   bit m_hold = 1'b0;
   int m_t0   = 0;

   bit auto_rep;
   initial begin
`ifdef PRESS_DECODER_AUTO_REPEAT_EN
      auto_rep = 1'b1;
`else
      auto_rep = 1'b0;
`endif
   end

   typedef struct {
      logic       r;
      logic       b;
      logic [5:0] exp;  // {press, release, click, long, repeat, held}
   } vec_t;

   function automatic logic [5:0] outs();
      return {press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse, held};
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h (edge %0d)", nm, act, exp, cyc);
   endtask

   task automatic model(input logic r, input logic b, output logic [5:0] e);
      int d;
      e = '0;
      if (r) begin
         m_hold = 1'b0;
      end else if (!m_hold) begin
         if (b) begin
            m_hold = 1'b1;
            m_t0   = cyc;
            e[5]   = 1'b1;
         end
      end else begin
         d = cyc - m_t0;
         if (!b) begin
            m_hold = 1'b0;
            e[4]   = 1'b1;
            if (d <= int'(LONG_CYC)) e[3] = 1'b1;
         end else begin
            if (d == int'(LONG_CYC)) e[2] = 1'b1;
            if (auto_rep && d > int'(LONG_CYC) && ((d - int'(LONG_CYC)) % int'(REPEAT_CYC)) == 0)
               e[1] = 1'b1;
         end
      end
      e[0] = m_hold;
   endtask

   task automatic step(input logic r, input logic b, input bit cmp, input string nm,
                       output logic [5:0] act);
      logic [5:0] e;
      @(negedge clk);
      rst       = r;
      btn_level = b;
      @(posedge clk);
      #1;
      cyc++;
      model(r, b, e);
      act = outs();
      if (cmp) check(nm, 32'(act), 32'(e));
   endtask

   initial begin
      vec_t       vecs[12];
      logic [5:0] a;
      int         t_press, t_long, n_rep, n_long;
      int         rep_d[$];

      vecs[0]  = '{1'b1, 1'b0, 6'b000000};
      vecs[1]  = '{1'b0, 1'b0, 6'b000000};
      vecs[2]  = '{1'b0, 1'b1, 6'b100001};
      vecs[3]  = '{1'b0, 1'b1, 6'b000001};
      vecs[4]  = '{1'b0, 1'b1, 6'b000001};
      vecs[5]  = '{1'b0, 1'b1, 6'b000001};
      vecs[6]  = '{1'b0, 1'b0, 6'b011000};
      vecs[7]  = '{1'b0, 1'b1, 6'b100001};
      vecs[8]  = '{1'b0, 1'b0, 6'b011000};
      vecs[9]  = '{1'b0, 1'b1, 6'b100001};
      vecs[10] = '{1'b0, 1'b0, 6'b011000};
      vecs[11] = '{1'b0, 1'b0, 6'b000000};

      // Reset, then idle with the button up.
      step(1'b1, 1'b0, 1'b0, "", a);
      check("reset_outs", 32'(a), 32'd0);
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b0, 1'b0, "", a);
         check("idle_outs", 32'(a), 32'd0);
      end

      // Short press and back-to-back one-cycle presses.
      for (int i = 0; i < 12; i++) begin
         step(vecs[i].r, vecs[i].b, 1'b0, "", a);
         check($sformatf("vec%0d", i), 32'(a), 32'(vecs[i].exp));
      end

      // Hold 20 cycles: long at +8, repeats at +3/+6/+9, release on a would-be repeat edge.
      t_press = -1; t_long = -1; rep_d.delete();
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b1, 1'b1, "long_hold", a);
         if (a[5]) t_press = cyc;
         if (a[2]) t_long  = cyc;
         if (a[1]) rep_d.push_back(cyc - t_long);
      end
      step(1'b0, 1'b0, 1'b0, "", a);
      check("long_release", 32'(a), 32'b010000);
      check("long_delay", 32'(t_long - t_press), 32'(LONG_CYC));
      if (auto_rep) begin
         check("repeat_count", 32'(rep_d.size()), 32'd3);
         for (int k = 0; k < rep_d.size() && k < 3; k++)
            check("repeat_delay", 32'(rep_d[k]), 32'((k + 1) * REPEAT_CYC));
      end else begin
         check("repeat_count", 32'(rep_d.size()), 32'd0);
      end
      step(1'b0, 1'b0, 1'b1, "gap", a);

      // Release sampled exactly on the long threshold edge counts as a click.
      n_long = 0;
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b1, 1'b1, "edge_hold", a);
         n_long += int'(a[2]);
      end
      step(1'b0, 1'b0, 1'b0, "", a);
      n_long += int'(a[2]);
      check("edge_release", 32'(a), 32'b011000);
      check("edge_no_long", 32'(n_long), 32'd0);
      step(1'b0, 1'b0, 1'b1, "gap", a);

      // Reset while in LONG with the button still down.
      for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b1, "pre_rst", a);
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 1'b1, 1'b0, "", a);
         check("rst_mid_long", 32'(a), 32'd0);
      end
      step(1'b0, 1'b1, 1'b0, "", a);
      check("press_after_rst", 32'(a), 32'b100001);
      step(1'b0, 1'b0, 1'b0, "", a);
      check("release_after_rst", 32'(a), 32'b011000);

      // Random level streams with occasional reset, checked every edge.
      n_rep = 0;
      for (int run = 0; run < 200; run++) begin
         logic lvl;
         int   len;
         lvl = run[0];
         len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : int'($urandom_range(1, 6));
         for (int i = 0; i < len; i++) begin
            logic r;
            r = ($urandom_range(0, 99) == 0);
            step(r, lvl, 1'b1, "random", a);
            n_rep += int'(a[1]);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

endmodule
